// File: rtl/count_sweep_ctrl.sv
// Sweep controller for an external 8-bit up/down counter: drives m/load/data_out so the
// counter walks a lo->hi->lo triangle, keeps a shadow count and flags lockstep loss.
module count_sweep_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [7:0]       n_sweeps,
  input  logic [WIDTH-1:0] count_fb,
  input  logic             err_clr,
  output logic             m,
  output logic             load,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic [7:0]       sweep_cnt,
  output logic             sweep_done,
  output logic             sync_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] lo_q, hi_q, data_out_q;
  logic [7:0]       n_q, sweep_cnt_q, cnt_inc_s;
  logic             m_q, load_q, busy_q, done_q, err_q;
  logic             mismatch_s;

  // Shadow of the counter's next value and the lockstep comparison against its output
  always_comb begin
    sh_d       = load_q ? data_out_q : (m_q ? sh_q + ONE : sh_q - ONE);
    mismatch_s = (count_fb != sh_q);
    cnt_inc_s  = (sweep_cnt_q == 8'hFF) ? 8'hFF : sweep_cnt_q + 8'd1;
  end

  // Sweep state machine with all counter controls and status registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      n_q         <= 8'd0;
      m_q         <= 1'b0;
      load_q      <= 1'b1;
      data_out_q  <= '0;
      busy_q      <= 1'b0;
      sweep_cnt_q <= 8'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      done_q <= 1'b0;
      if (mismatch_s) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end else begin
        err_q <= err_q;
      end
      case (state_q)
        ST_IDLE: begin
          load_q     <= 1'b1;
          data_out_q <= sh_d;
          busy_q     <= 1'b0;
          if (start && !stop && (lo < hi)) begin
            lo_q        <= lo;
            hi_q        <= hi;
            n_q         <= n_sweeps;
            sweep_cnt_q <= 8'd0;
            data_out_q  <= lo;
            busy_q      <= 1'b1;
            state_q     <= ST_UP;
          end
        end
        ST_UP, ST_DOWN: begin
          // Abort or lockstep loss freezes the counter at the value it just took
          if (stop || mismatch_s) begin
            state_q    <= ST_IDLE;
            load_q     <= 1'b1;
            data_out_q <= sh_d;
            busy_q     <= 1'b0;
          end else if (state_q == ST_UP) begin
            load_q <= 1'b0;
            if (sh_d == hi_q) begin
              m_q     <= 1'b0;
              state_q <= ST_DOWN;
            end else begin
              m_q <= 1'b1;
            end
          end else begin
            load_q <= 1'b0;
            if (sh_d == lo_q) begin
              sweep_cnt_q <= cnt_inc_s;
              if ((n_q != 8'd0) && (cnt_inc_s == n_q)) begin
                done_q     <= 1'b1;
                state_q    <= ST_IDLE;
                load_q     <= 1'b1;
                data_out_q <= lo_q;
                busy_q     <= 1'b0;
              end else begin
                m_q     <= 1'b1;
                state_q <= ST_UP;
              end
            end else begin
              m_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          load_q     <= 1'b1;
          data_out_q <= sh_d;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign m          = m_q;
  assign load       = load_q;
  assign data_out   = data_out_q;
  assign busy       = busy_q;
  assign sweep_cnt  = sweep_cnt_q;
  assign sweep_done = done_q;
  assign sync_err   = err_q;

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Bench for count_sweep_ctrl: emulates the external counter, predicts the triangle
// trace arithmetically and compares every cycle, plus hand-computed spot checks.
module tb_count_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, err_clr = 1'b0, inject = 1'b0;
  logic [7:0] lo = 8'd0, hi = 8'd0, n_sweeps = 8'd0;
  logic [7:0] count_fb, data_out, sweep_cnt;
  logic       m, load, busy, sweep_done, sync_err;
  logic [7:0] cnt;

  int total = 0;
  int bad = 0;

  count_sweep_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .lo(lo), .hi(hi),
    .n_sweeps(n_sweeps), .count_fb(count_fb), .err_clr(err_clr),
    .m(m), .load(load), .data_out(data_out), .busy(busy),
    .sweep_cnt(sweep_cnt), .sweep_done(sweep_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // The external up/down counter the controller drives
  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 8'd0;
    else     cnt <= load ? data_out : (m ? cnt + 8'd1 : cnt - 8'd1);
  end
  assign count_fb = inject ? (cnt ^ 8'd1) : cnt;

  // Model: triangle position t counted from the lo load
  bit m_run = 0, m_pend = 0, m_done = 0, m_err = 0;
  int m_t = 0, m_lo = 0, m_hi = 0, m_n = 0, m_freeze = 0, m_cnt = 0, m_count = 0;

  function automatic int tri_val(int t);
    int d, p, x;
    d = m_hi - m_lo;
    p = 2 * d;
    x = t % p;
    return m_lo + ((x <= d) ? x : p - x);
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_pend = 0; m_done = 0; m_err = 0;
      m_freeze = 0; m_cnt = 0; m_count = 0; m_t = 0;
    end else begin
      int nv;
      m_done = 0;
      if (m_run) begin
        nv = m_pend ? m_lo : tri_val(m_t + 1);
        m_count = nv;
        if (stop || inject) begin
          m_run = 0; m_pend = 0; m_freeze = nv;
        end else begin
          if (m_pend) begin m_pend = 0; m_t = 0; end
          else m_t = m_t + 1;
          if (m_t > 0 && (m_t % (2 * (m_hi - m_lo))) == 0) begin
            if (m_cnt < 255) m_cnt = m_cnt + 1;
            if (m_n != 0 && m_t == 2 * (m_hi - m_lo) * m_n) begin
              m_done = 1; m_run = 0; m_freeze = m_lo;
            end
          end
        end
      end else begin
        m_count = m_freeze;
        if (start && !stop && (lo < hi)) begin
          m_run = 1; m_pend = 1; m_cnt = 0;
          m_lo = int'(lo); m_hi = int'(hi); m_n = int'(n_sweeps);
        end
      end
      m_err = inject ? 1'b1 : (err_clr ? 1'b0 : m_err);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("count", int'(cnt), m_count);
      chk("busy", int'(busy), int'(m_run));
      chk("sweep_cnt", int'(sweep_cnt), m_cnt);
      chk("sweep_done", int'(sweep_done), int'(m_done));
      chk("sync_err", int'(sync_err), int'(m_err));
      chk("load", int'(load), int'(!m_run || m_pend));
      if (!m_run || m_pend) chk("data_out", int'(data_out), m_pend ? m_lo : m_freeze);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input int l, input int h, input int n);
    lo = l[7:0]; hi = h[7:0]; n_sweeps = n[7:0];
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int exp_tr [15] = '{3, 4, 5, 6, 5, 4, 3, 4, 5, 6, 5, 4, 3, 3, 3};
  int done_cnt, done_idx, prev_dout;
  bit found;

  initial begin
    // 1: reset
    step(3);
    rst = 1'b0;
    chk("rst_load", int'(load), 1);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_busy", int'(busy), 0);
    step(5);
    chk("rst_count_held", int'(cnt), 0);
    chk("rst_sync_err", int'(sync_err), 0);

    // 2: lo=3 hi=6 two sweeps, capture the trace
    pulse_start(3, 6, 2);
    done_cnt = 0; done_idx = -1;
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("trace", int'(cnt), exp_tr[i]);
      if (sweep_done) begin done_cnt++; done_idx = i; end
    end
    chk("done_pulses", done_cnt, 1);
    chk("done_index", done_idx, 12);
    chk("sweeps_total", int'(sweep_cnt), 2);
    chk("busy_after_done", int'(busy), 0);
    step();

    // 3: free-running full range, stop at 100
    pulse_start(0, 255, 0);
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (cnt == 8'd100) found = 1;
      else step();
    end
    chk("reached_100", int'(found), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step(3);
    chk("frozen_101", int'(cnt), 101);
    pulse_start(0, 255, 0);
    step();
    chk("restart_0", int'(cnt), 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step(2);

    // 4: illegal bounds and start while busy
    prev_dout = int'(data_out);
    pulse_start(7, 7, 1);
    step(2);
    chk("eq_bounds_busy", int'(busy), 0);
    chk("eq_bounds_dout", int'(data_out), prev_dout);
    pulse_start(9, 2, 1);
    step(2);
    chk("inv_bounds_busy", int'(busy), 0);
    chk("inv_bounds_dout", int'(data_out), prev_dout);
    pulse_start(3, 6, 0);
    step(4);
    pulse_start(10, 20, 0);
    step(8);
    chk("busy_restart_range", int'(cnt >= 8'd3 && cnt <= 8'd6), 1);

    // 5: lockstep loss mid-sweep, then clearing
    inject = 1'b1;
    step();
    inject = 1'b0;
    chk("err_set", int'(sync_err), 1);
    chk("err_idle", int'(busy), 0);
    step(3);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cleared", int'(sync_err), 0);
    inject = 1'b1; err_clr = 1'b1;
    step();
    inject = 1'b0; err_clr = 1'b0;
    chk("err_set_wins", int'(sync_err), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cleared2", int'(sync_err), 0);

    // 6: stop+start together, then stop on the final lo
    lo = 8'd3; hi = 8'd6; n_sweeps = 8'd1;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    step();
    chk("stop_start_busy", int'(busy), 0);
    pulse_start(3, 6, 1);
    step(6);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("final_stop_busy", int'(busy), 0);
    chk("final_stop_done", int'(sweep_done), 0);
    chk("final_stop_cnt", int'(sweep_cnt), 0);
    step(2);
    chk("final_stop_count", int'(cnt), 3);

    // Reset mid-sweep
    pulse_start(3, 6, 0);
    step(4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_dout", int'(data_out), 0);
    chk("mid_rst_count", int'(cnt), 0);
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
